// File: rtl/reg_bcd_converter_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_bcd_converter_if
// Brief    : start/busy/done handshake and result bus of the BCD converter
// Revision : 1.0 - initial release
// ============================================================================
interface reg_bcd_converter_if #(
    parameter int IN_WIDTH = 8
);
    logic                start;
    logic [IN_WIDTH-1:0] bin;
    logic                busy;
    logic                done;
    logic [3:0]          tens;
    logic [3:0]          units;
    logic                overflow;

    modport master (
        output start, bin,
        input  busy, done, tens, units, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, tens, units, overflow
    );
endinterface
`default_nettype wire

// File: rtl/reg_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : reg_bcd_converter
// Brief    : iterative double-dabble binary to two-digit BCD, saturating at 99
// Revision : 1.0 - initial release
// ============================================================================
module reg_bcd_converter #(
    parameter int IN_WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    reg_bcd_converter_if.slave  bus
);
    localparam int                  c_CNT_W   = $clog2(IN_WIDTH);
    localparam logic [IN_WIDTH-1:0] c_MAX_BCD = IN_WIDTH'(99);
    localparam logic [c_CNT_W-1:0]  c_CNT_LD  = c_CNT_W'(IN_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [7:0]          r_scratch;
    logic [IN_WIDTH-1:0] r_shift;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_ovf_flag;
    logic                r_busy;
    logic                r_done;
    logic [3:0]          r_tens;
    logic [3:0]          r_units;
    logic                r_overflow;

    logic [3:0]          w_adj_hi;
    logic [3:0]          w_adj_lo;
    logic [7:0]          w_next_scratch;
    logic [IN_WIDTH-1:0] w_next_shift;

    // Add-3 correction on each nibble, then one left shift of the whole chain
    always_comb begin
        w_adj_lo = (r_scratch[3:0] >= 4'd5) ? r_scratch[3:0] + 4'd3 : r_scratch[3:0];
        w_adj_hi = (r_scratch[7:4] >= 4'd5) ? r_scratch[7:4] + 4'd3 : r_scratch[7:4];
        {w_next_scratch, w_next_shift} = {w_adj_hi, w_adj_lo, r_shift} << 1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_scratch  <= 8'd0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_ovf_flag <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tens     <= 4'd0;
            r_units    <= 4'd0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_shift    <= bus.bin;
                        r_scratch  <= 8'd0;
                        r_cnt      <= c_CNT_LD;
                        r_ovf_flag <= (bus.bin > c_MAX_BCD);
                        r_busy     <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_next_scratch;
                    r_shift   <= w_next_shift;
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        // Out-of-range values still run full length, then saturate
                        if (r_ovf_flag) begin
                            r_tens     <= 4'd9;
                            r_units    <= 4'd9;
                            r_overflow <= 1'b1;
                        end else begin
                            r_tens     <= w_next_scratch[7:4];
                            r_units    <= w_next_scratch[3:0];
                            r_overflow <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.tens     = r_tens;
    assign bus.units    = r_units;
    assign bus.overflow = r_overflow;
endmodule
`default_nettype wire

// File: doc/reg_bcd_converter.md
# reg_bcd_converter

Sequential binary-to-BCD converter that turns one register or data-memory value into a two-digit decimal (tens/units) for the seven-segment path. It sits between the RISC-V core's debug taps and the `bcd_to_7seg` decoders, in the `clock_divider` output domain. It replaces a combinational divide-by-10 with an iterative double-dabble engine. A start/busy/done handshake lets one instance be time-shared across several display values.

## Interface
Parameters:
- `IN_WIDTH`, default 8: width of the binary input; legal range 7..32.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a conversion; sampled only while `busy`=0.
- `bin`, input, IN_WIDTH: unsigned value to convert; sampled on the accepting edge only.
- `busy`, output, 1: high while a conversion is in progress.
- `done`, output, 1: single-cycle pulse when `tens`/`units`/`overflow` update.
- `tens`, output, 4: BCD tens digit, 0..9.
- `units`, output, 4: BCD units digit, 0..9.
- `overflow`, output, 1: high when the last converted value was > 99.

## Operation
- States:
  - IDLE (`busy`=0).
  - SHIFT (`busy`=1).
  - DONE (`busy`=1, `done`=1).
- IDLE -> SHIFT on `start`=1:
  - Latch `bin` into the shift register.
  - Clear the 8-bit BCD scratch.
  - Load the bit counter with IN_WIDTH-1.
  - Latch the overflow flag as `bin` > 99.
- SHIFT, once per cycle:
  - For each scratch nibble >= 5, add 3 to that nibble.
  - Shift {scratch, shift register} left by one.
  - Decrement the counter.
  - After the counter reaches 0 and the final shift completes, go to DONE.
- Carries out of the 8-bit scratch are discarded. The result is only meaningful when `bin` <= 99.
- Entering DONE:
  - If the overflow flag is 0: `tens` = scratch[7:4], `units` = scratch[3:0], `overflow` = 0.
  - If the overflow flag is 1: `tens` = 9, `units` = 9, `overflow` = 1 (saturate).
- DONE -> IDLE unconditionally after one cycle.
- `start` is ignored in SHIFT and DONE; it is not queued.
- `tens`, `units` and `overflow` hold their value between completions. They change only on the edge that enters DONE.
- Latency is independent of the value. Overflow cases still run all IN_WIDTH shift cycles.

## Timing
- Reset values:
  - State = IDLE.
  - `busy` = 0, `done` = 0.
  - `tens` = 0, `units` = 0, `overflow` = 0.
  - Scratch, shift register and counter = 0.
- Reset has priority over every other event, including an in-flight conversion and a simultaneous `start`.
- After reset deasserts, the first `start` is accepted on the next edge.
- Sequence for `start`=1 in IDLE at edge k:
  - `busy` goes high after edge k.
  - SHIFT occupies edges k+1 .. k+IN_WIDTH.
  - `done` is high for exactly the cycle after edge k+IN_WIDTH, with outputs valid in that same cycle.
  - `busy` falls after edge k+IN_WIDTH+1.
- Total: IN_WIDTH+1 cycles from acceptance to `done`. Back-to-back accept rate is one conversion per IN_WIDTH+2 cycles.
- `start` held high continuously gives one conversion per IN_WIDTH+2 cycles. Each conversion samples `bin` on the edge where the block is in IDLE.
- `bin` may change freely while `busy`=1 without affecting the result.
- `done` never lasts more than one cycle and never asserts without a preceding accepted `start`.

## Test plan
- IN_WIDTH=8, reset for 2 cycles, then idle -> `busy`=0, `done`=0, `tens`=0, `units`=0, `overflow`=0 throughout.
- `bin`=42, 1-cycle `start` at edge k -> `done` high only in the cycle after edge k+8, with `tens`=4, `units`=2, `overflow`=0. `busy` high for exactly 9 cycles.
- Sweep `bin`=0..99, back-to-back with `start` held high -> each `done` shows the correct digits, e.g. 0 -> 0/0, 9 -> 0/9, 10 -> 1/0, 99 -> 9/9. `done` pulses are 10 cycles apart.
- `bin`=100 and `bin`=255 -> `tens`=9, `units`=9, `overflow`=1. A following `bin`=7 -> 0/7 with `overflow`=0. Repeat with IN_WIDTH=32 and `bin`=0xFFFFFFFF -> 9/9, `overflow`=1, `done` after 33 cycles.
- `bin`=56 accepted, then `start`=1 with `bin`=13 during SHIFT, and `bin` changed mid-conversion -> a single `done` with 5/6. The second request is not executed.
- `bin`=88 accepted, `reset` asserted at the 4th SHIFT cycle -> no `done`, and all outputs are 0 the cycle after. A new `bin`=21 afterwards -> 2/1 with normal latency.
